// File: rtl/vend_pkg.sv
// Shared types and helpers for the vend sequencer: FSM states, error codes,
// coin-unit decoding and the fixed price table.
package vend_pkg;

    localparam int NUM_SLOTS = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_SOLD_OUT = 2'd1,
        ERR_NO_FUNDS = 2'd2,
        ERR_JAM      = 2'd3
    } err_t;

    // Credit is kept in 5-cent units: 5c, 10c, 25c, 50c.
    function automatic logic [3:0] coin_units(input logic [1:0] code);
        case (code)
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            2'd2:    return 4'd5;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [4:0] price_of(input logic [3:0] slot);
        return {1'b0, slot} + 5'd2;
    endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Bundle of every vend_sequencer signal except clock and reset; the
// master side stimulates (keypad, coin acceptor, motor, hopper), the slave side is the controller.
interface vend_sequencer_if #(
    parameter int CREDIT_W = 8
);
    logic                valid_product;
    logic [3:0]          product_no;
    logic                coin_valid;
    logic [1:0]          coin_value;
    logic                cancel;
    logic                restock;
    logic                motor_done;
    logic                change_ack;
    logic                motor_start;
    logic [3:0]          motor_slot;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amount;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic [1:0]          err_code;

    modport master (
        output valid_product, product_no, coin_valid, coin_value, cancel,
               restock, motor_done, change_ack,
        input  motor_start, motor_slot, change_valid, change_amount,
               coin_reject, credit, busy, err_code
    );

    modport slave (
        input  valid_product, product_no, coin_valid, coin_value, cancel,
               restock, motor_done, change_ack,
        output motor_start, motor_slot, change_valid, change_amount,
               coin_reject, credit, busy, err_code
    );

endinterface

// File: rtl/stock_table.sv
// Per-slot stock counters with one read/modify port, a jam-restore increment
// and a bulk reload; reset loads every slot with STOCK_INIT.
module stock_table
    import vend_pkg::*;
#(
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         slot,
    input  logic               dec,
    input  logic               inc,
    input  logic               reload,
    output logic [STOCK_W-1:0] level
);

    logic [STOCK_W-1:0] stock [NUM_SLOTS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (reload) begin
            for (int i = 0; i < NUM_SLOTS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (dec) begin
            stock[slot] <= stock[slot] - STOCK_W'(1);
        end else if (inc) begin
            stock[slot] <= stock[slot] + STOCK_W'(1);
        end
    end

    assign level = stock[slot];

endmodule

// File: rtl/vend_sequencer.sv
// Top-level vend controller: credit accounting, price/stock check, motor
// start/done handshake with jam timeout, and change return to the hopper.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int CREDIT_W      = 8,
    parameter int MAX_CREDIT    = 200,
    parameter int STOCK_W       = 4,
    parameter int STOCK_INIT    = 5,
    parameter int MOTOR_TIMEOUT = 1000
) (
    input logic             clock,
    input logic             reset,
    vend_sequencer_if.slave bus
);

    localparam int TMO_W = $clog2(MOTOR_TIMEOUT + 1);

    state_t              state;
    err_t                err;
    logic [CREDIT_W-1:0] credit;
    logic [3:0]          slot;
    logic                motor_start_r;
    logic                coin_reject_r;
    logic [TMO_W-1:0]    tmo_cnt;

    logic [STOCK_W-1:0]  stock_level;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] idle_credit;
    logic                can_buy;
    logic                tmo_last;
    logic                jam;

    assign price    = CREDIT_W'(price_of(slot));
    assign coin_sum = {1'b0, credit} + (CREDIT_W + 1)'(coin_units(bus.coin_value));
    assign coin_ok  = coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT);

    // A coin landing in the same IDLE cycle as cancel/select is counted first.
    assign idle_credit = (bus.coin_valid && coin_ok) ? coin_sum[CREDIT_W-1:0] : credit;

    assign can_buy  = (stock_level != '0) && (credit >= price);
    assign tmo_last = tmo_cnt == TMO_W'(MOTOR_TIMEOUT - 1);
    assign jam      = (state == DISPENSE) && !bus.motor_done && tmo_last;

    stock_table #(
        .STOCK_W   (STOCK_W),
        .STOCK_INIT(STOCK_INIT)
    ) u_stock (
        .clock (clock),
        .reset (reset),
        .slot  (slot),
        .dec   ((state == CHECK) && can_buy),
        .inc   (jam),
        .reload((state == IDLE) && bus.restock),
        .level (stock_level)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            err           <= ERR_NONE;
            credit        <= '0;
            slot          <= '0;
            motor_start_r <= 1'b0;
            coin_reject_r <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            motor_start_r <= 1'b0;
            coin_reject_r <= 1'b0;
            case (state)
                IDLE: begin
                    coin_reject_r <= bus.coin_valid && !coin_ok;
                    credit        <= idle_credit;
                    if (bus.cancel && (idle_credit != '0)) begin
                        err   <= ERR_NONE;
                        state <= CHANGE;
                    end else if (bus.valid_product) begin
                        slot  <= bus.product_no;
                        err   <= ERR_NONE;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    coin_reject_r <= bus.coin_valid;
                    if (stock_level == '0) begin
                        err   <= ERR_SOLD_OUT;
                        state <= IDLE;
                    end else if (credit < price) begin
                        err   <= ERR_NO_FUNDS;
                        state <= IDLE;
                    end else begin
                        credit        <= credit - price;
                        motor_start_r <= 1'b1;
                        tmo_cnt       <= '0;
                        state         <= DISPENSE;
                    end
                end
                DISPENSE: begin
                    coin_reject_r <= bus.coin_valid;
                    // A done pulse on the timeout cycle still counts as a good vend.
                    if (bus.motor_done) begin
                        state <= (credit != '0) ? CHANGE : IDLE;
                    end else if (tmo_last) begin
                        err    <= ERR_JAM;
                        credit <= credit + price;
                        state  <= CHANGE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                CHANGE: begin
                    coin_reject_r <= bus.coin_valid;
                    if (bus.change_ack) begin
                        credit <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.motor_start   = motor_start_r;
    assign bus.motor_slot    = slot;
    assign bus.change_valid  = state == CHANGE;
    assign bus.change_amount = (state == CHANGE) ? credit : '0;
    assign bus.coin_reject   = coin_reject_r;
    assign bus.credit        = credit;
    assign bus.busy          = state != IDLE;
    assign bus.err_code      = err;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer, built with a short motor
// timeout so the jam path is reached quickly.
module tb_vend_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passes = 0;

    vend_sequencer_if #(.CREDIT_W(8)) vif ();

    vend_sequencer #(
        .CREDIT_W     (8),
        .MAX_CREDIT   (200),
        .STOCK_W      (4),
        .STOCK_INIT   (5),
        .MOTOR_TIMEOUT(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (vif)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic insert_coin(input logic [1:0] code);
        vif.coin_valid = 1'b1;
        vif.coin_value = code;
        tick();
        vif.coin_valid = 1'b0;
    endtask

    task automatic select_slot(input logic [3:0] p);
        vif.valid_product = 1'b1;
        vif.product_no    = p;
        tick();
        vif.valid_product = 1'b0;
    endtask

    task automatic pulse_done();
        vif.motor_done = 1'b1;
        tick();
        vif.motor_done = 1'b0;
    endtask

    task automatic pulse_ack();
        vif.change_ack = 1'b1;
        tick();
        vif.change_ack = 1'b0;
    endtask

    task automatic pulse_cancel();
        vif.cancel = 1'b1;
        tick();
        vif.cancel = 1'b0;
    endtask

    task automatic flush_credit();
        if (vif.credit != 8'd0) begin
            pulse_cancel();
            pulse_ack();
        end
    endtask

    // One coin, one selection; reports whether the motor started 2 cycles later.
    task automatic buy(input logic [3:0] p, input logic [1:0] code,
                       output logic started, output logic [1:0] err);
        insert_coin(code);
        select_slot(p);
        tick();
        started = vif.motor_start;
        err     = vif.err_code;
        if (started) begin
            pulse_done();
            if (vif.change_valid) pulse_ack();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (vif.motor_start !== 1'b0) $display("FAIL reset_motor_start: got %0b expected 0", vif.motor_start); else passes++;
        checks++; if (vif.change_valid !== 1'b0) $display("FAIL reset_change_valid: got %0b expected 0", vif.change_valid); else passes++;
        checks++; if (vif.coin_reject !== 1'b0) $display("FAIL reset_coin_reject: got %0b expected 0", vif.coin_reject); else passes++;
        checks++; if (vif.credit !== 8'd0) $display("FAIL reset_credit: got %0d expected 0", vif.credit); else passes++;
        checks++; if (vif.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", vif.busy); else passes++;
        checks++; if (vif.err_code !== 2'd0) $display("FAIL reset_err: got %0d expected 0", vif.err_code); else passes++;
        checks++; if (vif.change_amount !== 8'd0) $display("FAIL reset_change_amount: got %0d expected 0", vif.change_amount); else passes++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_purchase();
        insert_coin(2'd2);
        insert_coin(2'd1);
        checks++; if (vif.credit !== 8'd7) $display("FAIL buy_credit: got %0d expected 7", vif.credit); else passes++;
        select_slot(4'd3);
        checks++; if (vif.motor_start !== 1'b0) $display("FAIL buy_early_start: got %0b expected 0", vif.motor_start); else passes++;
        checks++; if (vif.busy !== 1'b1) $display("FAIL buy_busy_check: got %0b expected 1", vif.busy); else passes++;
        tick();
        checks++; if (vif.motor_start !== 1'b1) $display("FAIL buy_motor_start: got %0b expected 1", vif.motor_start); else passes++;
        checks++; if (vif.motor_slot !== 4'd3) $display("FAIL buy_motor_slot: got %0d expected 3", vif.motor_slot); else passes++;
        checks++; if (vif.credit !== 8'd2) $display("FAIL buy_credit_after: got %0d expected 2", vif.credit); else passes++;
        pulse_done();
        checks++; if (vif.motor_start !== 1'b0) $display("FAIL buy_start_pulse: got %0b expected 0", vif.motor_start); else passes++;
        checks++; if (vif.change_valid !== 1'b1) $display("FAIL buy_change_valid: got %0b expected 1", vif.change_valid); else passes++;
        checks++; if (vif.change_amount !== 8'd2) $display("FAIL buy_change_amount: got %0d expected 2", vif.change_amount); else passes++;
        pulse_ack();
        checks++; if (vif.credit !== 8'd0) $display("FAIL buy_credit_cleared: got %0d expected 0", vif.credit); else passes++;
        checks++; if (vif.change_valid !== 1'b0) $display("FAIL buy_change_drop: got %0b expected 0", vif.change_valid); else passes++;
        checks++; if (vif.busy !== 1'b0) $display("FAIL buy_idle: got %0b expected 0", vif.busy); else passes++;
    endtask

    task automatic test_no_funds();
        insert_coin(2'd1);
        select_slot(4'd4);
        tick();
        checks++; if (vif.err_code !== 2'd2) $display("FAIL nofunds_err: got %0d expected 2", vif.err_code); else passes++;
        checks++; if (vif.motor_start !== 1'b0) $display("FAIL nofunds_start: got %0b expected 0", vif.motor_start); else passes++;
        checks++; if (vif.credit !== 8'd2) $display("FAIL nofunds_credit: got %0d expected 2", vif.credit); else passes++;
        checks++; if (vif.busy !== 1'b0) $display("FAIL nofunds_idle: got %0b expected 0", vif.busy); else passes++;
        pulse_cancel();
        checks++; if (vif.err_code !== 2'd0) $display("FAIL cancel_err_clear: got %0d expected 0", vif.err_code); else passes++;
        checks++; if (vif.change_amount !== 8'd2) $display("FAIL cancel_change: got %0d expected 2", vif.change_amount); else passes++;
        pulse_ack();
        checks++; if (vif.credit !== 8'd0) $display("FAIL cancel_credit: got %0d expected 0", vif.credit); else passes++;
    endtask

    task automatic test_sold_out();
        logic       started;
        logic [1:0] err;
        for (int i = 0; i < 5; i++) begin
            buy(4'd0, 2'd1, started, err);
            checks++; if (started !== 1'b1) $display("FAIL soldout_buy%0d: got %0b expected 1", i, started); else passes++;
        end
        buy(4'd0, 2'd1, started, err);
        checks++; if (started !== 1'b0) $display("FAIL soldout_start: got %0b expected 0", started); else passes++;
        checks++; if (err !== 2'd1) $display("FAIL soldout_err: got %0d expected 1", err); else passes++;
        checks++; if (vif.credit !== 8'd2) $display("FAIL soldout_credit: got %0d expected 2", vif.credit); else passes++;
        vif.restock = 1'b1;
        tick();
        vif.restock = 1'b0;
        select_slot(4'd0);
        tick();
        checks++; if (vif.motor_start !== 1'b1) $display("FAIL restock_start: got %0b expected 1", vif.motor_start); else passes++;
        pulse_done();
        checks++; if (vif.busy !== 1'b0) $display("FAIL restock_idle: got %0b expected 0", vif.busy); else passes++;
        checks++; if (vif.err_code !== 2'd0) $display("FAIL restock_err: got %0d expected 0", vif.err_code); else passes++;
    endtask

    task automatic test_jam();
        logic       started;
        logic [1:0] err;
        insert_coin(2'd3);
        select_slot(4'd0);
        tick();
        checks++; if (vif.credit !== 8'd8) $display("FAIL jam_credit_debit: got %0d expected 8", vif.credit); else passes++;
        insert_coin(2'd0);
        checks++; if (vif.coin_reject !== 1'b1) $display("FAIL dispense_coin_reject: got %0b expected 1", vif.coin_reject); else passes++;
        checks++; if (vif.credit !== 8'd8) $display("FAIL dispense_coin_credit: got %0d expected 8", vif.credit); else passes++;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (vif.change_valid !== 1'b0) $display("FAIL jam_early: got %0b expected 0", vif.change_valid); else passes++;
        checks++; if (vif.busy !== 1'b1) $display("FAIL jam_busy: got %0b expected 1", vif.busy); else passes++;
        tick();
        checks++; if (vif.err_code !== 2'd3) $display("FAIL jam_err: got %0d expected 3", vif.err_code); else passes++;
        checks++; if (vif.change_valid !== 1'b1) $display("FAIL jam_change_valid: got %0b expected 1", vif.change_valid); else passes++;
        checks++; if (vif.change_amount !== 8'd10) $display("FAIL jam_refund: got %0d expected 10", vif.change_amount); else passes++;
        pulse_ack();
        checks++; if (vif.err_code !== 2'd3) $display("FAIL jam_sticky: got %0d expected 3", vif.err_code); else passes++;
        // Slot 0 held 4 before the jam; exactly 4 more vends must succeed.
        for (int i = 0; i < 4; i++) begin
            buy(4'd0, 2'd1, started, err);
            checks++; if (started !== 1'b1) $display("FAIL jam_stock_buy%0d: got %0b expected 1", i, started); else passes++;
        end
        buy(4'd0, 2'd1, started, err);
        checks++; if (err !== 2'd1) $display("FAIL jam_stock_empty: got %0d expected 1", err); else passes++;
        flush_credit();
    endtask

    task automatic test_coin_limit();
        for (int i = 0; i < 19; i++) insert_coin(2'd3);
        insert_coin(2'd2);
        checks++; if (vif.credit !== 8'd195) $display("FAIL limit_credit: got %0d expected 195", vif.credit); else passes++;
        insert_coin(2'd3);
        checks++; if (vif.coin_reject !== 1'b1) $display("FAIL limit_reject: got %0b expected 1", vif.coin_reject); else passes++;
        checks++; if (vif.credit !== 8'd195) $display("FAIL limit_reject_credit: got %0d expected 195", vif.credit); else passes++;
        tick();
        checks++; if (vif.coin_reject !== 1'b0) $display("FAIL limit_reject_pulse: got %0b expected 0", vif.coin_reject); else passes++;
        insert_coin(2'd2);
        checks++; if (vif.credit !== 8'd200) $display("FAIL limit_exact: got %0d expected 200", vif.credit); else passes++;
        checks++; if (vif.coin_reject !== 1'b0) $display("FAIL limit_exact_reject: got %0b expected 0", vif.coin_reject); else passes++;
        insert_coin(2'd0);
        checks++; if (vif.coin_reject !== 1'b1) $display("FAIL limit_over: got %0b expected 1", vif.coin_reject); else passes++;
        pulse_cancel();
        checks++; if (vif.change_amount !== 8'd200) $display("FAIL limit_refund: got %0d expected 200", vif.change_amount); else passes++;
        pulse_ack();
    endtask

    task automatic test_reset_mid();
        logic       started;
        logic [1:0] err;
        insert_coin(2'd1);
        pulse_cancel();
        checks++; if (vif.change_valid !== 1'b1) $display("FAIL midreset_pre: got %0b expected 1", vif.change_valid); else passes++;
        reset = 1'b1;
        #1;
        checks++; if (vif.change_valid !== 1'b0) $display("FAIL midreset_change_valid: got %0b expected 0", vif.change_valid); else passes++;
        checks++; if (vif.credit !== 8'd0) $display("FAIL midreset_credit: got %0d expected 0", vif.credit); else passes++;
        checks++; if (vif.busy !== 1'b0) $display("FAIL midreset_busy: got %0b expected 0", vif.busy); else passes++;
        tick();
        reset = 1'b0;
        tick();
        // Slot 0 was empty before reset; a vend now proves the reload.
        buy(4'd0, 2'd1, started, err);
        checks++; if (started !== 1'b1) $display("FAIL midreset_restock: got %0b expected 1", started); else passes++;
        checks++; if (err !== 2'd0) $display("FAIL midreset_err: got %0d expected 0", err); else passes++;
    endtask

    initial begin
        vif.valid_product = 1'b0;
        vif.product_no    = 4'd0;
        vif.coin_valid    = 1'b0;
        vif.coin_value    = 2'd0;
        vif.cancel        = 1'b0;
        vif.restock       = 1'b0;
        vif.motor_done    = 1'b0;
        vif.change_ack    = 1'b0;
        test_reset();
        test_purchase();
        test_no_funds();
        test_sold_out();
        test_jam();
        test_coin_limit();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
